// File: rtl/and_chk_pkg.sv
// Shared types and defaults for the ALU response checker.
package and_chk_pkg;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/and_ref_model.sv
// Golden result and signed-overflow flag for one ALU operation.
module and_ref_model
  import and_chk_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] busA,
  input  logic [DATA_W-1:0] busB,
  output logic [DATA_W-1:0] expOut,
  output logic              expOvf
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              aMsb;
  logic              bMsb;

  assign sum  = busA + busB;
  assign diff = busA - busB;
  assign aMsb = busA[DATA_W-1];
  assign bMsb = busB[DATA_W-1];

  always_comb begin
    expOut = '0;
    expOvf = 1'b0;
    unique case (op_e'(op))
      OP_AND: expOut = busA & busB;
      OP_OR:  expOut = busA | busB;
      OP_ADD: begin
        expOut = sum;
        expOvf = (aMsb == bMsb) &
                 (sum[DATA_W-1] != aMsb);
      end
      OP_SUB: begin
        expOut = diff;
        expOvf = (aMsb != bMsb) &
                 (diff[DATA_W-1] != aMsb);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/and_response_checker.sv
// Two-stage pipelined ALU response checker with pass/fail counters.
// Define AND_CHECKER_OVF_EN to also compare the overflow flag.
module and_response_checker
  import and_chk_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] busA,
  input  logic [DATA_W-1:0] busB,
  input  logic [DATA_W-1:0] busOut,
  input  logic              ovf,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef AND_CHECKER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] MAXC = '1;

  state_e state;
  state_e stateNext;

  logic accept;
  logic clear;

  logic [CNT_W-1:0] vecIdx;

  logic              s1Valid;
  logic [1:0]        s1Op;
  logic [DATA_W-1:0] s1A;
  logic [DATA_W-1:0] s1B;
  logic [DATA_W-1:0] s1Out;
  logic              s1Ovf;
  logic [CNT_W-1:0]  s1Idx;

  logic [DATA_W-1:0] refOut;
  logic              refOvf;

  logic              s2Valid;
  logic [DATA_W-1:0] s2Exp;
  logic              s2ExpOvf;
  logic [DATA_W-1:0] s2Out;
  logic              s2Ovf;
  logic [CNT_W-1:0]  s2Idx;

  logic mismatch;

  assign in_ready = (state == S_RUN) & ~stop;
  assign accept   = in_valid & in_ready;
  assign busy     = (state == S_RUN) |
                    (state == S_DRAIN);
  assign done     = (state == S_DONE);
  assign clear    = start &
                    ((state == S_IDLE) |
                     (state == S_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      S_IDLE, S_DONE:
        if (start) stateNext = S_RUN;
      S_RUN:
        if (stop) stateNext = S_DRAIN;
      S_DRAIN:
        if (!s1Valid && !s2Valid)
          stateNext = S_DONE;
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid <= 1'b0;
      s1Op    <= '0;
      s1A     <= '0;
      s1B     <= '0;
      s1Out   <= '0;
      s1Ovf   <= 1'b0;
      s1Idx   <= '0;
    end else begin
      s1Valid <= accept;
      if (accept) begin
        s1Op  <= op;
        s1A   <= busA;
        s1B   <= busB;
        s1Out <= busOut;
        s1Ovf <= ovf;
        s1Idx <= vecIdx;
      end
    end
  end

  and_ref_model #(
    .DATA_W (DATA_W)
  ) uRef (
    .op     (s1Op),
    .busA   (s1A),
    .busB   (s1B),
    .expOut (refOut),
    .expOvf (refOvf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid  <= 1'b0;
      s2Exp    <= '0;
      s2ExpOvf <= 1'b0;
      s2Out    <= '0;
      s2Ovf    <= 1'b0;
      s2Idx    <= '0;
    end else begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        s2Exp    <= refOut;
        s2ExpOvf <= refOvf;
        s2Out    <= s1Out;
        s2Ovf    <= s1Ovf;
        s2Idx    <= s1Idx;
      end
    end
  end

  assign mismatch = (s2Out != s2Exp) |
                    (OVF_EN &
                     (s2Ovf != s2ExpOvf));

  // A new session only starts with an empty pipe,
  // so clear never races a retiring beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vecIdx         <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      err            <= 1'b0;
    end else if (clear) begin
      vecIdx         <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      err            <= 1'b0;
    end else begin
      if (accept && vecIdx != MAXC)
        vecIdx <= vecIdx + 1'b1;
      if (s2Valid) begin
        if (mismatch) begin
          if (fail_cnt != MAXC)
            fail_cnt <= fail_cnt + 1'b1;
          if (!err)
            first_fail_idx <= s2Idx;
          err <= 1'b1;
        end else if (pass_cnt != MAXC) begin
          pass_cnt <= pass_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_and_response_checker.sv
// Directed bench with a session-level scoreboard model.
module tb_and_response_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] busA = '0;
  logic [31:0] busB = '0;
  logic [31:0] busOut = '0;
  logic        ovf = 1'b0;

  logic        inReady;
  logic [15:0] passCnt;
  logic [15:0] failCnt;
  logic [15:0] firstFail;
  logic        busy;
  logic        done;
  logic        err;

  logic        inReady4;
  logic [3:0]  passCnt4;
  logic [3:0]  failCnt4;
  logic [3:0]  firstFail4;
  logic        busy4;
  logic        done4;
  logic        err4;

  and_response_checker #(
    .CNT_W (16),
    .DATA_W(32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .in_valid      (in_valid),
    .in_ready      (inReady),
    .op            (op),
    .busA          (busA),
    .busB          (busB),
    .busOut        (busOut),
    .ovf           (ovf),
    .pass_cnt      (passCnt),
    .fail_cnt      (failCnt),
    .first_fail_idx(firstFail),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  and_response_checker #(
    .CNT_W (4),
    .DATA_W(32)
  ) dut4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .in_valid      (in_valid),
    .in_ready      (inReady4),
    .op            (op),
    .busA          (busA),
    .busB          (busB),
    .busOut        (busOut),
    .ovf           (ovf),
    .pass_cnt      (passCnt4),
    .fail_cnt      (failCnt4),
    .first_fail_idx(firstFail4),
    .busy          (busy4),
    .done          (done4),
    .err           (err4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Session model: 0 idle, 1 run, 2 drain, 3 done
  localparam longint MAXC = 65535;

  typedef struct {
    bit     ok;
    longint idx;
    longint due;
  } ent_t;

  ent_t   pipeQ[$];
  int     mPhase = 0;
  longint mPass = 0;
  longint mFail = 0;
  longint mFirst = 0;
  longint mIdx = 0;
  bit     mErr = 0;
  longint edgeN = 0;
  bit     wasEmpty;
  bit     acc;

  function automatic bit verdict(
    input logic [1:0]  o,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] out,
    input logic        f);
    longint sa;
    longint sb;
    longint r;
    logic [31:0] er;
    bit eo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    eo = 0;
    er = '0;
    case (o)
      2'd0: er = a & b;
      2'd1: er = a | b;
      default: begin
        r  = (o == 2'd2) ? sa + sb : sa - sb;
        er = r[31:0];
        eo = (r > 64'sd2147483647) ||
             (r < -64'sd2147483648);
      end
    endcase
`ifdef AND_CHECKER_OVF_EN
    return (er == out) && (eo == f);
`else
    return (er == out);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipeQ.delete();
      mPhase = 0;
      mPass = 0;
      mFail = 0;
      mFirst = 0;
      mIdx = 0;
      mErr = 0;
    end else begin
      wasEmpty = (pipeQ.size() == 0);
      acc = (mPhase == 1) && !stop && in_valid;
      edgeN++;
      while (pipeQ.size() > 0 &&
             pipeQ[0].due == edgeN) begin
        if (pipeQ[0].ok) begin
          if (mPass < MAXC) mPass++;
        end else begin
          if (mFail < MAXC) mFail++;
          if (!mErr) mFirst = pipeQ[0].idx;
          mErr = 1;
        end
        void'(pipeQ.pop_front());
      end
      if (acc) begin
        pipeQ.push_back('{
          verdict(op, busA, busB, busOut, ovf),
          mIdx, edgeN + 2});
        if (mIdx < MAXC) mIdx++;
      end
      if ((mPhase == 0 || mPhase == 3) && start) begin
        mPhase = 1;
        mPass = 0;
        mFail = 0;
        mFirst = 0;
        mIdx = 0;
        mErr = 0;
      end else if (mPhase == 1 && stop) begin
        mPhase = 2;
      end else if (mPhase == 2 && wasEmpty) begin
        mPhase = 3;
      end
    end
  end

  always @(negedge clk) begin
    chk("passCnt", passCnt, mPass);
    chk("failCnt", failCnt, mFail);
    chk("firstFail", firstFail, mFirst);
    chk("err", err, mErr);
    chk("busy", busy, mPhase == 1 || mPhase == 2);
    chk("done", done, mPhase == 3);
    chk("inReady", inReady, mPhase == 1 && !stop);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0]  o,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] out,
                      input logic        f);
    in_valid = 1'b1;
    op = o;
    busA = a;
    busB = b;
    busOut = out;
    ovf = f;
    tick();
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 40 && !done; i++) tick();
    chk("doneReached", done, 1);
  endtask

  task automatic endSession();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    waitDone();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] o;

    tick();
    tick();
    chk("rstBusy", busy, 0);
    chk("rstDone", done, 0);
    chk("rstPass", passCnt, 0);
    chk("rstReady", inReady, 0);
    rst_n = 1'b1;
    tick();

    pulseStart();
    beat(2'd0, 32'h01010101, 32'hFFFFFFFF,
         32'h01010101, 1'b0);
    in_valid = 1'b0;
    endSession();
    chk("t1Pass", passCnt, 1);
    chk("t1Fail", failCnt, 0);
    chk("t1Err", err, 0);
    chk("t1Done", done, 1);

    pulseStart();
    beat(2'd2, 32'h7FFFFFFF, 32'h7FFFFFFF,
         32'hFFFFFFFE, 1'b1);
    beat(2'd2, 32'h7FFFFFFF, 32'h7FFFFFFF,
         32'hFFFFFFFE, 1'b0);
    in_valid = 1'b0;
    endSession();
`ifdef AND_CHECKER_OVF_EN
    chk("t2Pass", passCnt, 1);
    chk("t2Fail", failCnt, 1);
    chk("t2First", firstFail, 1);
`else
    chk("t2Pass", passCnt, 2);
    chk("t2Fail", failCnt, 0);
`endif

    pulseStart();
    for (int i = 0; i < 8; i++) begin
      a = 32'h01000005 * (i + 1);
      b = 32'h00000100 + i;
      o = a + b;
      if (i == 3 || i == 6) o = o ^ 32'h1;
      beat(2'd2, a, b, o, 1'b0);
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("t3Pass", passCnt, 6);
    chk("t3Fail", failCnt, 2);
    chk("t3First", firstFail, 3);
    chk("t3Err", err, 1);
    endSession();

    pulseStart();
    beat(2'd1, 32'hF0, 32'h0F, 32'hFF, 1'b0);
    beat(2'd3, 32'h80000000, 32'h1,
         32'h7FFFFFFF, 1'b1);
    stop = 1'b1;
    #1;
    chk("t4ReadyDrop", inReady, 0);
    tick();
    stop = 1'b0;
    in_valid = 1'b0;
    chk("t4Busy", busy, 1);
    waitDone();
    chk("t4Pass", passCnt, 2);
    chk("t4Fail", failCnt, 0);

    pulseStart();
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      beat(2'd0, i, 32'hFFFFFFFF, i, 1'b0);
    end
    start = 1'b0;
    in_valid = 1'b0;
    endSession();
    chk("t5Pass", passCnt, 20);
    chk("t5Pass4", passCnt4, 15);
    chk("t5Fail4", failCnt4, 0);

    pulseStart();
    beat(2'd0, 32'hFF, 32'hFF, 32'h0, 1'b0);
    beat(2'd1, 32'h1, 32'h2, 32'h3, 1'b0);
    beat(2'd2, 32'h1, 32'h2, 32'h3, 1'b0);
    chk("t6ErrBefore", err, 1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6Pass", passCnt, 0);
    chk("t6Fail", failCnt, 0);
    chk("t6Err", err, 0);
    chk("t6Busy", busy, 0);
    chk("t6Ready", inReady, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t6PassAfter", passCnt, 0);
    chk("t6FailAfter", failCnt, 0);
    chk("t6Idle", busy | done, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
